// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the two-input gate self-tester.
// Truth tables are indexed by {A,B}.
package gate_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TRUTH_OR  = 4'b1110;
  localparam logic [3:0] TRUTH_AND = 4'b1000;
  localparam logic [3:0] TRUTH_XOR = 4'b0110;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, clearing to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta->q a true two-stage shift; blocking would collapse it to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gate_tester.sv
// Steps all four {A,B} vectors through an external gate, samples its synchronised output,
// and reports mismatching vectors, a mismatch count and an overall pass flag.
module gate_tester
  import gate_test_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] TRUTH         = TRUTH_OR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t     state, next_state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       c_sync;
  logic       mismatch;

  sync2 u_sync_c (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_c),
    .q     (c_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    mismatch   = (c_sync != TRUTH[idx]);
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (cnt == LAST_CNT) next_state = SAMPLE;
      SAMPLE:  next_state = (idx == 2'd3) ? DONE : SETTLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      cnt       <= 8'd0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= 2'd0;
            cnt       <= 8'd0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            pass      <= 1'b0;
          end
        end
        SETTLE: cnt <= cnt + 8'd1;
        SAMPLE: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            err_count     <= err_count + 3'd1;
          end
          if (idx != 2'd3) begin
            idx            <= idx + 2'd1;
            cnt            <= 8'd0;
            {dut_a, dut_b} <= idx + 2'd1;
          end
        end
        DONE: begin
          // fail_vec already holds the final SAMPLE update here
          pass  <= (fail_vec == 4'd0);
          dut_a <= 1'b0;
          dut_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench: three gate_tester instances (default, SETTLE_CYCLES=3, XOR truth) driving behavioural gate models.
module tb_gate_tester;
  import gate_test_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  int         mode;  // main model: 0 ideal OR, 1 C=A, 2 stuck at 0

  logic       a0, b0, c0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [3:0] fv0;
  logic       a1, b1, c1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  logic       a2, b2, c2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] fv2;

  int checks = 0;
  int errors = 0;
  int d0, d1, d2;

  always #5 clk = ~clk;

  assign c0 = (mode == 0) ? (a0 | b0) : (mode == 1) ? a0 : 1'b0;
  assign c1 = a1 | b1;
  assign c2 = a2 | b2;

  gate_tester u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a0), .dut_b(b0), .dut_c(c0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );

  gate_tester #(.SETTLE_CYCLES(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a1), .dut_b(b1), .dut_c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  gate_tester #(.TRUTH(TRUTH_XOR)) u_dut_xor (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a2), .dut_b(b2), .dut_c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse start in cycle 0 and record the cycle in which each instance shows done (-1 = never).
  task automatic run(output int r0, output int r1, output int r2);
    r0 = -1; r1 = -1; r2 = -1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0 && r0 < 0) r0 = c;
      if (done1 && r1 < 0) r1 = c;
      if (done2 && r2 < 0) r2 = c;
      if (r0 >= 0 && r1 >= 0 && r2 >= 0) break;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    check("rst_pins",  {30'd0, a0, b0}, 32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_pass",  {31'd0, pass0}, 32'd0);
    check("rst_err",   {29'd0, err0}, 32'd0);
    check("rst_fv",    {28'd0, fv0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal OR on all three instances
    run(d0, d1, d2);
    check("or_done_cyc", d0, 21);
    check("or_pass",     {31'd0, pass0}, 32'd1);
    check("or_err",      {29'd0, err0}, 32'd0);
    check("or_fv",       {28'd0, fv0}, 32'd0);
    check("s3_done_cyc", d1, 17);
    check("s3_pass",     {31'd0, pass1}, 32'd1);
    check("xor_done_cyc", d2, 21);
    check("xor_fv",      {28'd0, fv2}, 32'h8);
    check("xor_err",     {29'd0, err2}, 32'd1);
    check("xor_pass",    {31'd0, pass2}, 32'd0);

    // Buggy OR: C follows A only
    mode = 1;
    run(d0, d1, d2);
    check("bug_fv",   {28'd0, fv0}, 32'h2);
    check("bug_err",  {29'd0, err0}, 32'd1);
    check("bug_pass", {31'd0, pass0}, 32'd0);

    // Stuck at 0
    mode = 2;
    run(d0, d1, d2);
    check("stuck_fv",   {28'd0, fv0}, 32'he);
    check("stuck_err",  {29'd0, err0}, 32'd3);
    check("stuck_pass", {31'd0, pass0}, 32'd0);

    // Ideal rerun clears previous results
    mode = 0;
    run(d0, d1, d2);
    check("rerun_fv",   {28'd0, fv0}, 32'd0);
    check("rerun_err",  {29'd0, err0}, 32'd0);
    check("rerun_pass", {31'd0, pass0}, 32'd1);

    // Re-pulsed start during a run is ignored; pins step through the vectors
    d0 = -1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 15);
      if (c == 1) begin
        check("busy_c1",  {31'd0, busy0}, 32'd1);
        check("pass_clr", {31'd0, pass0}, 32'd0);
        check("pins_c1",  {30'd0, a0, b0}, 32'd0);
      end
      if (c == 6)  check("pins_c6",  {30'd0, a0, b0}, 32'd1);
      if (c == 11) check("pins_c11", {30'd0, a0, b0}, 32'd2);
      if (c == 16) check("pins_c16", {30'd0, a0, b0}, 32'd3);
      if (done0) begin d0 = c; break; end
    end
    check("repulse_done_cyc", d0, 21);
    @(negedge clk);
    check("idle_busy", {31'd0, busy0}, 32'd0);
    check("idle_pins", {30'd0, a0, b0}, 32'd0);

    // start held high: back-to-back runs
    d0 = -1; d1 = -1;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done0) begin
        if (d0 < 0) d0 = c;
        else begin d1 = c; break; end
      end
    end
    start = 1'b0;
    check("hold_first",  d0, 21);
    check("hold_second", d1, 43);
    repeat (30) @(negedge clk);

    // Reset mid-run at cycle 12
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_busy_pre", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_pins", {30'd0, a0, b0}, 32'd0);
    check("mid_busy", {31'd0, busy0}, 32'd0);
    check("mid_done", {31'd0, done0}, 32'd0);
    check("mid_pass", {31'd0, pass0}, 32'd0);
    check("mid_err",  {29'd0, err0}, 32'd0);
    check("mid_fv",   {28'd0, fv0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(d0, d1, d2);
    check("post_rst_done_cyc", d0, 21);
    check("post_rst_pass", {31'd0, pass0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
